// File: rtl/fetch_pkg.sv
// Shared constants for the instruction prefetch unit.
//   XLEN_DEF     : default address/PC width
//   DEPTH_DEF    : default instruction queue depth (power of two, >= 2)
//   RESET_PC_DEF : default first fetch address after reset
//   PC_INC       : byte distance between consecutive fetches
package fetch_pkg;
    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned DEPTH_DEF    = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned PC_INC       = 4;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue for the prefetch unit: DEPTH entries of WIDTH bits.
// Ports:
//   clk, rst (async, active-low)
//   flush            : empty the queue (wins over push/pop)
//   push, push_data  : write one entry (ignored when full)
//   pop              : drop the head entry (ignored when empty)
//   head_data        : head entry, zero while empty
//   count            : number of valid entries
module fetch_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != CW'(DEPTH));

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: issues sequential fetches under a credit rule,
// buffers in-order responses in a queue, and handles redirects by flushing
// the queue and discarding responses still owed by memory.
// Ports:
//   clk, rst (async, active-low)
//   irequest, pc_address_out   : fetch request / address to instruction memory
//   ivalid, instr_out          : memory response strobe / instruction word
//   instr_valid, instr, instr_pc, instr_ready : queue head handshake to decode
//   redirect, redirect_pc      : flush and restart fetch at a new target
//   resp_err                   : sticky flag, response arrived with none owed
module prefetch_unit import fetch_pkg::*; #(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter int unsigned     DEPTH    = DEPTH_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            irequest,
    output logic [XLEN-1:0] pc_address_out,
    input  logic            ivalid,
    input  logic [31:0]     instr_out,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            resp_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    resp_pc;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      discard;
    logic [CW-1:0]      count;
    logic [32+XLEN-1:0] head;
    logic               credit_ok;
    logic               spurious;
    logic               resp_ok;
    logic               push;
    logic               drop_one;

    // A slot is reserved in the queue for every outstanding request, so a
    // response can always be written without back-pressure.
    assign credit_ok = !redirect && (({1'b0, count} + {1'b0, inflight}) < (CW+1)'(DEPTH));
    assign irequest  = credit_ok && rst;
    assign pc_address_out = fetch_pc;

    assign spurious = ivalid && (inflight == '0) && (discard == '0);
    assign resp_ok  = ivalid && !spurious;
    // Stale responses (owed from before a redirect) are always older than
    // live ones, so they are consumed first.
    assign push     = resp_ok && !redirect && (discard == '0);
    assign drop_one = resp_ok && !redirect && (discard != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            resp_err <= 1'b0;
        end else begin
            if (spurious) resp_err <= 1'b1;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                inflight <= '0;
                // Everything still owed becomes stale, except a word that
                // lands in this very cycle.
                discard  <= discard + inflight - CW'(resp_ok);
            end else begin
                if (credit_ok) fetch_pc <= fetch_pc + XLEN'(PC_INC);
                if (push)      resp_pc  <= resp_pc + XLEN'(PC_INC);
                if (drop_one)  discard  <= discard - CW'(1);
                inflight <= inflight + CW'(credit_ok) - CW'(push);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32 + XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data ({instr_out, resp_pc}),
        .pop       (instr_ready && !redirect),
        .head_data (head),
        .count     (count)
    );

    assign instr_valid = (count != '0);
    assign instr       = head[XLEN +: 32];
    assign instr_pc    = head[XLEN-1:0];

endmodule

// File: tb/tb_prefetch_unit.sv
module tb_prefetch_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        irequest;
    logic [31:0] pc_address_out;
    logic        ivalid = 1'b0;
    logic [31:0] instr_out = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        resp_err;

    prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .irequest       (irequest),
        .pc_address_out (pc_address_out),
        .ivalid         (ivalid),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .resp_err       (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct { int unsigned due; logic [31:0] data; } mem_t;
    typedef struct { logic [31:0] pc;  logic [31:0] data; } exp_t;

    mem_t        mem_q[$];   // memory model: responses owed, in order
    exp_t        exp_q[$];   // scoreboard: live fetches not yet consumed
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    logic [31:0] model_pc = RESET_PC;
    int          n_req = 0;

    function automatic logic [31:0] code(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must match the oldest live fetch.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual_pc=%h expected=none", instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", instr_pc, e.pc);
                chk("pop_instr", instr, e.data);
            end
        end
    end

    // One clock cycle: drive inputs, then model the request handshake.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt,
                        input bit spur, input bit rel);
        mem_t m;
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (rel) rst = 1'b1;
        ivalid    = 1'b0;
        instr_out = '0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            ivalid    = 1'b1;
            instr_out = mem_q[0].data;
            void'(mem_q.pop_front());
        end else if (spur) begin
            ivalid    = 1'b1;
            instr_out = 32'hDEAD_BEEF;
        end
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = tgt;
        if (redir) begin
            exp_q.delete();
            model_pc = tgt;
        end
        #1;
        chk("irequest", {31'b0, irequest}, {31'b0, (!redir && exp_q.size() < DEPTH)});
        if (irequest) begin
            chk("req_addr", pc_address_out, model_pc);
            m.due  = cyc + lat;
            m.data = code(model_pc);
            mem_q.push_back(m);
            e.pc   = model_pc;
            e.data = code(model_pc);
            exp_q.push_back(e);
            model_pc = model_pc + 32'd4;
            n_req++;
        end
    endtask

    task automatic hard_reset();
        @(posedge clk);
        #3;
        rst         = 1'b0;
        ivalid      = 1'b0;
        instr_out   = '0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        #1;
        chk("rst_irequest", {31'b0, irequest}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_pc_address", pc_address_out, RESET_PC);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        mem_q.delete();
        exp_q.delete();
        model_pc = RESET_PC;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_head(input string name, input logic [31:0] exp_pc);
        int k = 0;
        do begin
            step(1'b1, 1'b0, '0, 1'b0, 1'b0);
            k++;
        end while (!instr_valid && k < 20);
        chk(name, instr_pc, exp_pc);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values, then streaming with 1-cycle memory.
        hard_reset();
        lat = 1;
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("no_bypass_valid", {31'b0, instr_valid}, 32'd0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("first_valid", {31'b0, instr_valid}, 32'd1);
        chk("first_pc", instr_pc, RESET_PC);
        repeat (10) step(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Decode stalled: exactly DEPTH requests, then a spurious response.
        hard_reset();
        n_req = 0;
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        repeat (9) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("stall_nreq", n_req, DEPTH);
        chk("stall_irequest", {31'b0, irequest}, 32'd0);
        chk("stall_head_pc", instr_pc, 32'd0);
        chk("pre_spur_err", {31'b0, resp_err}, 32'd0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("spur_err", {31'b0, resp_err}, 32'd1);
        chk("spur_irequest", {31'b0, irequest}, 32'd0);
        repeat (12) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("err_sticky", {31'b0, resp_err}, 32'd1);

        // Mid-stream reset clears everything, including the sticky error.
        hard_reset();

        // 3-cycle memory, redirect with two fetches owed.
        lat = 3;
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        wait_head("redir_first_pc", 32'h0000_0100);
        repeat (10) step(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // 1-cycle memory, redirect in the same cycle as a response.
        lat = 1;
        repeat (6) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("redir_flush_valid", {31'b0, instr_valid}, 32'd0);
        wait_head("redir_ivalid_pc", 32'h0000_0200);
        repeat (6) step(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Address wrap at the top of the space.
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
        wait_head("wrap_first_pc", 32'hFFFF_FFF8);
        repeat (8) step(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Back-to-back redirects: only the last target is fetched.
        lat = 2;
        step(1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b0);
        wait_head("b2b_first_pc", 32'h0000_0400);

        // Randomised phases with varying latency, stalls and redirects.
        for (int p = 0; p < 6; p++) begin
            lat = $urandom_range(1, 3);
            for (int i = 0; i < 300; i++) begin
                step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5,
                     $urandom & 32'hFFFF_FFFC, 1'b0, 1'b0);
            end
            if (p == 2) begin
                hard_reset();
                step(1'b1, 1'b0, '0, 1'b0, 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
